seg7_sampler: RTL and testbench
===============================

// Module: seg7_sampler
// PURPOSE
//  Upstream stage of the 7-segment-to-digit encoder. Samples a raw 7-bit segment bus (order a..g, MSB=a),
//  waits until the pattern has held for STABLE_CYCLES consecutive samples, and classifies it as blank,
//  legal digit code or illegal. A legal pattern is presented on seg_out with a one-cycle valid strobe;
//  seg_out drives the encoder input directly. An illegal pattern raises an error strobe instead.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before classifying (legal range 2..7)
//  STAB_W         3  width of stability counter; must hold STABLE_CYCLES-1
//  EMIT_W         8  width of emitted-digit counter
// PORTS
//  clk       in   1       clock, all state changes on rising edge
//  rst       in   1       synchronous reset, active-high
//  seg_in    in   7       raw segment pattern, asynchronous to meaning, sampled every cycle
//  seg_out   out  7       last accepted legal pattern (feeds encoder input)
//  valid     out  1       one-cycle pulse: seg_out updated with a newly accepted pattern
//  err       out  1       one-cycle pulse: stable pattern is neither blank nor legal
//  emit_cnt  out  EMIT_W  number of valid pulses since reset, wraps 2^EMIT_W-1 -> 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): in_q=0, cand=0, cnt=0, state=IDLE, seg_out=7'b0000000, valid=0, err=0,
//    emit_cnt=0. Reset mid-SETTLE aborts the pattern: no valid/err for it. All outputs registered.
//  - in_q <= seg_in every cycle (one sample stage). cand = pattern being qualified.
//  - Legal set (exactly ten): 1111110,0110000,1101101,1111001,0110011,1011011,1011111,1110000,1111111,
//    1110011 (digits 0..9). Blank = 0000000. Every other code is illegal.
//  - States: IDLE (blank stable), SETTLE, EMIT, ERR, HOLD.
//  - IDLE/HOLD: in_q != cand -> SETTLE, cand<=in_q, cnt<=1. Otherwise stay.
//  - SETTLE: in_q != cand -> restart (cand<=in_q, cnt<=1, stay SETTLE).
//    in_q == cand and cnt < STABLE_CYCLES-1 -> cnt<=cnt+1.
//    in_q == cand and cnt == STABLE_CYCLES-1 -> classify cand: blank -> IDLE (no pulse);
//    legal -> EMIT with seg_out<=cand, valid<=1, emit_cnt<=emit_cnt+1; illegal -> ERR with err<=1.
//  - EMIT and ERR last exactly one cycle, then HOLD; valid/err return to 0. If in_q != cand during EMIT/ERR,
//    the pulse still completes and the next state is SETTLE with cand<=in_q, cnt<=1.
//  - Latency: seg_in set to P at cycle t and held -> valid (or err) high in cycle t+STABLE_CYCLES+1
//    (t+5 at default). Any change before then restarts qualification; nothing emitted.
//  - A pattern held indefinitely emits once; re-emission of the same digit requires an intervening
//    different pattern (e.g. blank) that itself is sampled at least once.
//  - seg_out holds its value through IDLE, ERR, HOLD and SETTLE; only EMIT updates it.
//  - valid and err never high in the same cycle. emit_cnt increments only with valid; err does not count.
// TESTING
//  1. rst=1 two cycles with seg_in=1111001 -> all outputs zero; after release, valid at cycle 5, seg_out=1111001, emit_cnt=1.
//  2. seg_in=0110000 for 3 cycles then 1101101 held -> no pulse for 0110000; valid once with seg_out=1101101.
//  3. seg_in=1010101 held 10 cycles -> err single pulse at cycle 5, seg_out unchanged, emit_cnt unchanged.
//  4. 1111110 held 20 cycles, blank 1 cycle, 1111110 held -> exactly two valid pulses, none for blank.
//  5. Cycle all ten legal codes, 6 cycles each -> ten valid pulses, seg_out matches each code, emit_cnt=10.
//  6. EMIT_W=2, emit five legal digits -> emit_cnt sequence 1,2,3,0,1; rst mid-SETTLE -> no pulse.

Source files
------------

// File: rtl/seg7_sampler_if.sv
// Segment sampler bus: raw segment input plus the qualified-pattern outputs.
interface seg7_sampler_if #(
    parameter int unsigned EMIT_W = 8
);
    logic [6:0]        seg_in;
    logic [6:0]        seg_out;
    logic              valid;
    logic              err;
    logic [EMIT_W-1:0] emit_cnt;

    modport master (
        output seg_in,
        input  seg_out, valid, err, emit_cnt
    );

    modport slave (
        input  seg_in,
        output seg_out, valid, err, emit_cnt
    );
endinterface

// File: rtl/seg7_sampler.sv
// Samples a raw 7-segment bus, qualifies it over STABLE_CYCLES identical samples and
// classifies it as blank, a legal digit (valid pulse) or an illegal code (err pulse).
module seg7_sampler #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned STAB_W        = 3,
    parameter int unsigned EMIT_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    seg7_sampler_if.slave  bus
);
    localparam logic [STAB_W-1:0] CNT_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] CNT_ONE  = STAB_W'(1);
    localparam logic [6:0]        BLANK    = 7'b0000000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        EMIT   = 3'd2,
        ERR    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [6:0]        in_q;
    logic [6:0]        cand, cand_n;
    logic [STAB_W-1:0] cnt, cnt_n;
    logic [6:0]        seg_out_q, seg_out_n;
    logic              valid_q, valid_n;
    logic              err_q, err_n;
    logic [EMIT_W-1:0] emit_q, emit_n;

    // Digits 0..9, segment order a..g with a in the MSB.
    function automatic logic is_legal(input logic [6:0] p);
        case (p)
            7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011: is_legal = 1'b1;
            default:                                                    is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_q      <= BLANK;
            cand      <= BLANK;
            cnt       <= '0;
            seg_out_q <= BLANK;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            emit_q    <= '0;
        end else begin
            state     <= state_n;
            in_q      <= bus.seg_in;
            cand      <= cand_n;
            cnt       <= cnt_n;
            seg_out_q <= seg_out_n;
            valid_q   <= valid_n;
            err_q     <= err_n;
            emit_q    <= emit_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        seg_out_n = seg_out_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        emit_n    = emit_q;

        case (state)
            IDLE, HOLD, EMIT, ERR: begin
                // Pulse states always last one cycle; a change seen meanwhile starts a new qualification.
                if (in_q != cand) begin
                    state_n = SETTLE;
                    cand_n  = in_q;
                    cnt_n   = CNT_ONE;
                end else if (state == EMIT || state == ERR) begin
                    state_n = HOLD;
                end
            end
            SETTLE: begin
                if (in_q != cand) begin
                    cand_n = in_q;
                    cnt_n  = CNT_ONE;
                end else if (cnt < CNT_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else if (cand == BLANK) begin
                    state_n = IDLE;
                end else if (is_legal(cand)) begin
                    state_n   = EMIT;
                    seg_out_n = cand;
                    valid_n   = 1'b1;
                    emit_n    = emit_q + EMIT_W'(1);
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.seg_out  = seg_out_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.emit_cnt = emit_q;
endmodule

// File: tb/tb_seg7_sampler.sv
// Scoreboard bench for seg7_sampler: expected pulses are queued when a pattern is driven
// and matched against valid/err strobes of a default instance and an EMIT_W=2 instance.
module tb_seg7_sampler;
    localparam int unsigned LAT = 5;
    localparam logic [1:0]  K_NONE  = 2'b00;
    localparam logic [1:0]  K_VALID = 2'b10;
    localparam logic [1:0]  K_ERR   = 2'b01;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
        logic [6:0] seg;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic [7:0] exp_cnt;
    logic [6:0] exp_seg;

    seg7_sampler_if #(.EMIT_W(8)) bus1 ();
    seg7_sampler_if #(.EMIT_W(2)) bus2 ();

    seg7_sampler #(.STABLE_CYCLES(4), .STAB_W(3), .EMIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    seg7_sampler #(.STABLE_CYCLES(4), .STAB_W(3), .EMIT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Match every strobe against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (bus1.valid || bus1.err || bus2.valid || bus2.err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({bus1.valid, bus1.err, bus2.valid, bus2.err}), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("kind",      32'({bus1.valid, bus1.err}), 32'(e.kind));
                check("kind_w2",   32'({bus2.valid, bus2.err}), 32'(e.kind));
                check("latency",   32'(cyc), 32'(e.cyc));
                check("seg_out",   32'(bus1.seg_out), 32'(e.seg));
                check("emit_cnt",  32'(bus1.emit_cnt), 32'(e.cnt));
                check("emit_cnt_w2", 32'(bus2.emit_cnt), 32'(e.cnt[1:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [6:0] pat, input int n, input logic [1:0] kind);
        exp_t e;
        bus1.seg_in = pat;
        bus2.seg_in = pat;
        if (kind == K_VALID) begin
            exp_cnt = exp_cnt + 8'd1;
            exp_seg = pat;
        end
        if (kind != K_NONE) begin
            e.kind = kind;
            e.cyc  = cyc + LAT;
            e.seg  = exp_seg;
            e.cnt  = exp_cnt;
            exp_q.push_back(e);
        end
        tick(n);
    endtask

    task automatic drain(input string tag);
        tick(LAT + 2);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg_out"},  32'(bus1.seg_out), 32'd0);
        check({tag, "_valid"},    32'(bus1.valid), 32'd0);
        check({tag, "_err"},      32'(bus1.err), 32'd0);
        check({tag, "_emit_cnt"}, 32'(bus1.emit_cnt), 32'd0);
        check({tag, "_emit_w2"},  32'(bus2.emit_cnt), 32'd0);
    endtask

    logic [6:0] codes [10];

    initial begin
        codes = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
        exp_cnt = 8'd0;
        exp_seg = 7'b0;
        rst = 1'b1;
        bus1.seg_in = 7'b1111001;
        bus2.seg_in = 7'b1111001;
        tick(2);
        check_reset_state("reset");

        // Release with the digit already present: qualification starts from release.
        rst = 1'b0;
        apply(7'b1111001, 12, K_VALID);
        drain("missing_after_release");

        // Short-lived digit is dropped, the following held digit emits once.
        apply(7'b0110000, 3, K_NONE);
        apply(7'b1101101, 12, K_VALID);
        drain("missing_restart");

        // Illegal code: one err pulse, seg_out and emit_cnt unchanged.
        apply(7'b1010101, 10, K_ERR);
        drain("missing_err");

        // Same digit twice separated by a single blank sample.
        apply(7'b1111110, 20, K_VALID);
        apply(7'b0000000, 1, K_NONE);
        apply(7'b1111110, 12, K_VALID);
        drain("missing_reemit");

        // Blank back to IDLE, then all ten digits six cycles apiece.
        apply(7'b0000000, 6, K_NONE);
        for (int i = 0; i < 10; i++) apply(codes[i], 6, K_VALID);
        drain("missing_sweep");
        check("sweep_emit_cnt", 32'(bus1.emit_cnt), 32'(exp_cnt));

        // Fresh reset, then counter wrap on the narrow instance.
        rst = 1'b1;
        bus1.seg_in = 7'b0000000;
        bus2.seg_in = 7'b0000000;
        tick(2);
        check_reset_state("reset2");
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_seg = 7'b0;
        for (int i = 0; i < 5; i++) apply(codes[i], 6, K_VALID);
        drain("missing_wrap");
        check("wrap_emit_w2", 32'(bus2.emit_cnt), 32'd1);

        // Reset while a digit is still settling: no pulse for it.
        apply(7'b1110000, 3, K_NONE);
        rst = 1'b1;
        bus1.seg_in = 7'b0000000;
        bus2.seg_in = 7'b0000000;
        tick(1);
        rst = 1'b0;
        apply(7'b0000000, 10, K_NONE);
        drain("missing_abort");
        check_reset_state("abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
